// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared state encoding and default sizing for the sort job sequencer
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD,
    KICK,
    SORT,
    DRAIN
  } state_t;

  localparam int DW_DEF          = 8;
  localparam int DEPTH_DEF       = 8;
  localparam int AW_DEF          = 3;
  localparam int TIMEOUT_CYC_DEF = 1023;

endpackage

// File: rtl/sort_watchdog.sv
// rtl/sort_watchdog.sv - SORT-phase cycle counter; expire flags the LIMIT-th enabled cycle
module sort_watchdog #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of already-completed enabled cycles
  assign expire = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/sort_job_sequencer.sv
// rtl/sort_job_sequencer.sv - load/kick/sort/drain job FSM and single-port RAM mux for the sorter
// Optional WATCHDOG_EN adds a SORT timeout that forces DRAIN and raises sticky sort_err.
module sort_job_sequencer
  import sort_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int AW          = AW_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          job_done,
  output logic          busy,
  output logic          sort_err,
  output logic          srt_start,
  input  logic          srt_done,
  input  logic [AW-1:0] srt_addr,
  input  logic          srt_wr,
  input  logic [DW-1:0] srt_wdata,
  output logic [DW-1:0] srt_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          armed;
  logic          wd_expire;

`ifdef WATCHDOG_EN
  sort_watchdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (state == KICK),
    .en    (state == SORT),
    .expire(wd_expire)
  );
`else
  assign wd_expire = 1'b0;
  assign sort_err  = 1'b0;
`endif

  // Exactly one agent owns the RAM port per state; sorter writes never leak into LOAD/DRAIN
  always_comb begin
    mem_addr  = '0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    unique case (state)
      LOAD: begin
        mem_addr  = wr_ptr;
        mem_wr    = in_valid;
        mem_wdata = in_data;
      end
      KICK, SORT: begin
        mem_addr  = srt_addr;
        mem_wr    = srt_wr;
        mem_wdata = srt_wdata;
      end
      DRAIN: begin
        mem_addr = rd_ptr;
      end
      default: ;
    endcase
  end

  assign srt_rdata = mem_rdata;
  assign out_data  = out_valid ? mem_rdata : '0;
  assign job_done  = out_valid && out_ready && (rd_ptr == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      armed     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      srt_start <= 1'b0;
`ifdef WATCHDOG_EN
      sort_err  <= 1'b0;
`endif
    end else begin
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            if (wr_ptr == LAST) begin
              wr_ptr    <= '0;
              state     <= KICK;
              in_ready  <= 1'b0;
              busy      <= 1'b1;
              srt_start <= 1'b1;
`ifdef WATCHDOG_EN
              sort_err  <= 1'b0;
`endif
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        KICK: begin
          srt_start <= 1'b0;
          armed     <= 1'b0;
          state     <= SORT;
        end
        SORT: begin
          // A done level still high from the previous job is ignored until it drops once
          if (!srt_done) begin
            armed <= 1'b1;
          end
          if ((armed && srt_done) || wd_expire) begin
            state     <= DRAIN;
            busy      <= 1'b0;
            out_valid <= 1'b1;
`ifdef WATCHDOG_EN
            if (wd_expire) begin
              sort_err <= 1'b1;
            end
`endif
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_ptr == LAST) begin
              rd_ptr    <= '0;
              state     <= LOAD;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_job_sequencer.sv
// tb/tb_sort_job_sequencer.sv - self-checking bench with RAM model, behavioural sorter and sort reference
module tb_sort_job_sequencer;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef logic [DW-1:0] word_arr_t [DEPTH];

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          sw;
    logic [AW-1:0] sa;
    logic          exp_wr;
    logic [AW-1:0] exp_addr;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          job_done, busy, sort_err, srt_start, srt_done;
  logic [AW-1:0] srt_addr;
  logic          srt_wr;
  logic [DW-1:0] srt_wdata, srt_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] ram [DEPTH];

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int done_cnt  = 0;

  always #5 clk = ~clk;

  sort_job_sequencer #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .job_done(job_done), .busy(busy), .sort_err(sort_err),
    .srt_start(srt_start), .srt_done(srt_done),
    .srt_addr(srt_addr), .srt_wr(srt_wr), .srt_wdata(srt_wdata), .srt_rdata(srt_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr];

  always @(posedge clk) begin
    if (srt_start) start_cnt <= start_cnt + 1;
    if (job_done)  done_cnt  <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic word_arr_t sorted_of(input word_arr_t d);
    logic [DW-1:0] q[$];
    word_arr_t s;
    foreach (d[i]) q.push_back(d[i]);
    q.sort();
    foreach (s[i]) s[i] = q[i];
    return s;
  endfunction

  task automatic load_job(input word_arr_t d);
    int i = 0;
    int guard = 0;
    while (i < DEPTH && guard < 100) begin
      in_valid  = (guard > 50) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      in_data   = in_valid ? d[i] : 8'($urandom);
      srt_wr    = 1'($urandom);
      srt_addr  = 3'($urandom);
      srt_wdata = 8'($urandom);
      #1;
      check("load_ready", in_ready, 1);
      check("load_wr", mem_wr, in_valid);
      if (in_valid) i++;
      guard++;
      step();
    end
    check("load_count", i, DEPTH);
    in_valid = 1'b0;
    srt_wr   = 1'b0;
  endtask

  // Entered in the KICK cycle; sorter writes the sorted words back, then raises done
  task automatic run_sorter(input word_arr_t d, input bit stale);
    word_arr_t s;
    s = sorted_of(d);
    srt_wr   = 1'b0;
    srt_done = stale;
    #1;
    check("kick_start", srt_start, 1);
    check("kick_busy", busy, 1);
    check("kick_ready", in_ready, 0);
    step();
    #1;
    check("sort1_busy", busy, 1);
    check("sort1_start_low", srt_start, 0);
    check("sort1_no_drain", out_valid, 0);
    step();
    srt_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      srt_addr  = 3'(i);
      srt_wr    = 1'b1;
      srt_wdata = s[i];
      #1;
      check("sort_rdata", srt_rdata, d[i]);
      check("sort_mux", {mem_wr, mem_addr, mem_wdata}, {1'b1, 3'(i), s[i]});
      check("sort_no_drain", out_valid, 0);
      step();
    end
    srt_wr   = 1'b0;
    srt_done = 1'b1;
    step();
  endtask

  task automatic drain_job(input word_arr_t exp, input int mode);
    int idx = 0;
    int cyc = 0;
    while (idx < DEPTH && cyc < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom);
      endcase
      srt_wr    = 1'($urandom);
      srt_addr  = 3'($urandom);
      srt_wdata = 8'($urandom);
      #1;
      check("drain_valid", out_valid, 1);
      check("drain_no_wr", mem_wr, 0);
      check("drain_data", out_data, exp[idx]);
      check("drain_done", job_done, out_ready && (idx == DEPTH - 1));
      if (out_ready) idx++;
      cyc++;
      step();
    end
    check("drain_count", idx, DEPTH);
    out_ready = 1'b0;
    srt_wr    = 1'b0;
    #1;
    check("post_drain_ready", in_ready, 1);
    check("post_drain_valid", out_valid, 0);
  endtask

  initial begin
    vec_t      tbl[10];
    word_arr_t basic;
    word_arr_t basic_sorted;
    word_arr_t d;
    int        s0, d0, n;

    tbl[0] = '{1'b1, 8'd90, 1'b1, 3'd5, 1'b1, 3'd0};
    tbl[1] = '{1'b0, 8'd33, 1'b1, 3'd2, 1'b0, 3'd1};
    tbl[2] = '{1'b1, 8'd25, 1'b0, 3'd0, 1'b1, 3'd1};
    tbl[3] = '{1'b1, 8'd60, 1'b1, 3'd7, 1'b1, 3'd2};
    tbl[4] = '{1'b1, 8'd15, 1'b0, 3'd0, 1'b1, 3'd3};
    tbl[5] = '{1'b0, 8'd77, 1'b1, 3'd0, 1'b0, 3'd4};
    tbl[6] = '{1'b1, 8'd30, 1'b0, 3'd0, 1'b1, 3'd4};
    tbl[7] = '{1'b1, 8'd75, 1'b1, 3'd3, 1'b1, 3'd5};
    tbl[8] = '{1'b1, 8'd45, 1'b0, 3'd0, 1'b1, 3'd6};
    tbl[9] = '{1'b1, 8'd10, 1'b1, 3'd1, 1'b1, 3'd7};
    basic        = '{8'd90, 8'd25, 8'd60, 8'd15, 8'd30, 8'd75, 8'd45, 8'd10};
    basic_sorted = '{8'd10, 8'd15, 8'd25, 8'd30, 8'd45, 8'd60, 8'd75, 8'd90};
    foreach (ram[i]) ram[i] = '0;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    srt_done = 1'b0; srt_addr = '0; srt_wr = 1'b0; srt_wdata = '0;
    repeat (3) step();
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_start", srt_start, 0);
    check("rst_job_done", job_done, 0);
    check("rst_sort_err", sort_err, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    step();

    // Basic job through the vector table, stale done, 1,0,0,1 backpressure
    s0 = start_cnt; d0 = done_cnt;
    for (int k = 0; k < 10; k++) begin
      in_valid  = tbl[k].iv;
      in_data   = tbl[k].d;
      srt_wr    = tbl[k].sw;
      srt_addr  = tbl[k].sa;
      srt_wdata = 8'hEE;
      #1;
      check("vec_ready", in_ready, 1);
      check("vec_wr", mem_wr, tbl[k].exp_wr);
      check("vec_addr", mem_addr, tbl[k].exp_addr);
      check("vec_wdata", mem_wdata, tbl[k].d);
      step();
    end
    in_valid = 1'b0;
    srt_wr   = 1'b0;
    run_sorter(basic, 1'b1);
    drain_job(basic_sorted, 1);
    check("basic_starts", start_cnt - s0, 1);
    check("basic_job_done", done_cnt - d0, 1);

    // Reset in the 5th SORT cycle, then a clean job
    foreach (d[i]) d[i] = 8'($urandom);
    load_job(d);
    srt_done = 1'b0;
    repeat (5) step();
    #1;
    check("mid_sort_busy", busy, 1);
    rst = 1'b1;
    step();
    #1;
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_start", srt_start, 0);
    check("rst_mid_valid", out_valid, 0);
    rst = 1'b0;
    foreach (d[i]) d[i] = 8'($urandom);
    s0 = start_cnt; d0 = done_cnt;
    load_job(d);
    run_sorter(d, 1'b0);
    drain_job(sorted_of(d), 0);
    check("after_rst_starts", start_cnt - s0, 1);
    check("after_rst_job_done", done_cnt - d0, 1);

    // Randomized jobs against the sorted-multiset reference
    for (int j = 0; j < 4; j++) begin
      foreach (d[i]) d[i] = 8'($urandom_range(0, (j == 0) ? 3 : 255));
      s0 = start_cnt; d0 = done_cnt;
      load_job(d);
      run_sorter(d, 1'($urandom));
      drain_job(sorted_of(d), 2);
      check("rand_starts", start_cnt - s0, 1);
      check("rand_job_done", done_cnt - d0, 1);
    end

`ifdef WATCHDOG_EN
    foreach (d[i]) d[i] = 8'($urandom);
    load_job(d);
    srt_done = 1'b0;
    srt_wr   = 1'b0;
    step();
    n = 0;
    while (n < 100) begin
      #1;
      if (out_valid) break;
      n++;
      step();
    end
    check("wd_sort_cycles", n, 16);
    check("wd_err_set", sort_err, 1);
    drain_job(d, 0);
    check("wd_err_sticky", sort_err, 1);
    foreach (d[i]) d[i] = 8'($urandom);
    load_job(d);
    #1;
    check("wd_err_cleared", sort_err, 0);
    run_sorter(d, 1'b0);
    drain_job(sorted_of(d), 0);
    check("wd_err_normal_job", sort_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_job_sequencer.md
Name: sort_job_sequencer

Overview:
- Job-level scheduler wrapped around the in-place sorter (controller + datapath) and its single-port 8x8 RAM.
- Accepts DEPTH words from a host over valid/ready and writes them into RAM, pulses the sorter start, and waits for sorter done.
- Then streams the sorted contents back to the host over valid/ready.
- Owns the RAM port mux: host loader, sorter, or host drain, never two at once.

Parameters:
- DW, 8, data word width
- DEPTH, 8, number of words per job (power of 2, >=2)
- AW, 3, address width, equals log2(DEPTH)
- TIMEOUT_CYC, 1023, watchdog limit in SORT cycles (used only with WATCHDOG_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  host load word valid
- in_ready  out  1  sequencer accepts a load word
- in_data  in  DW  load word
- out_valid  out  1  sorted word valid
- out_ready  in  1  host accepts the sorted word
- out_data  out  DW  sorted word
- job_done  out  1  one-cycle pulse when the last sorted word is accepted
- busy  out  1  high in KICK and SORT
- sort_err  out  1  watchdog expiry flag
- srt_start  out  1  sorter start (s)
- srt_done  in  1  sorter done
- srt_addr  in  AW  sorter RAM address
- srt_wr  in  1  sorter RAM write enable
- srt_wdata  in  DW  sorter write data
- srt_rdata  out  DW  RAM read data passed to the sorter
- mem_addr  out  AW  RAM address
- mem_wr  out  1  RAM write enable
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data (asynchronous read)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- On reset: state=LOAD, wr_ptr=0, rd_ptr=0, armed=0, all outputs 0 except in_ready=1. RAM contents are not cleared.
- LOAD:
  - in_ready=1.
  - mem_addr=wr_ptr, mem_wdata=in_data, mem_wr=in_valid.
  - Each handshake increments wr_ptr.
  - A handshake with wr_ptr==DEPTH-1 sets wr_ptr to 0 and moves to KICK.
- KICK: one cycle. srt_start=1, busy=1, armed cleared. Moves to SORT.
- SORT:
  - busy=1. mem_addr/mem_wr/mem_wdata come from srt_addr/srt_wr/srt_wdata.
  - armed is set on the first cycle srt_done==0.
  - Moves to DRAIN when armed==1 and srt_done==1. A done level left high from the previous job is ignored.
- srt_rdata=mem_rdata in every state. srt_wr is gated off (mem_wr=0) outside KICK/SORT.
- DRAIN:
  - out_valid=1, mem_addr=rd_ptr, out_data=mem_rdata (combinational, zero latency), mem_wr=0.
  - Each handshake increments rd_ptr.
  - The handshake at rd_ptr==DEPTH-1 pulses job_done, sets rd_ptr to 0 and moves to LOAD.
  - out_data is held stable while out_valid && !out_ready.
- in_ready=0 outside LOAD. out_valid=0 outside DRAIN.
- Pointers are AW bits and wrap only through the explicit transitions above.
- Reset mid-operation (any state) returns to LOAD in the next cycle. srt_start is deasserted and a partial load or drain is discarded.

Optional Feature:
- Macro: WATCHDOG_EN.
- Defined:
  - A cycle counter clears in KICK and increments in SORT.
  - When it reaches TIMEOUT_CYC: sort_err is set (sticky until rst or the next KICK) and the FSM moves to DRAIN.
  - The drained data is whatever the RAM holds.
- Undefined: no counter; sort_err is tied 0; SORT waits indefinitely.

Decomposition:
- Package sort_pkg holds:
  - the state enum (LOAD, KICK, SORT, DRAIN);
  - default DW/AW/DEPTH constants;
  - the TIMEOUT_CYC default.
- The RAM mux and FSM live in one module.
- The watchdog is a natural sub-module, sort_watchdog (counter with clear/enable/expire), instantiated only under WATCHDOG_EN.

Test Plan:
- Basic job: load 90,25,60,15,30,75,45,10 with the behavioural sorter model -> exactly one srt_start pulse; drain yields 10,15,25,30,45,60,75,90; one job_done pulse.
- Backpressure: out_ready toggles 1,0,0,1 during DRAIN -> out_data is stable while stalled; no word is skipped or duplicated; rd_ptr wraps to 0.
- Stale done: the model holds srt_done=1 through KICK and the first SORT cycle -> no DRAIN until done falls then rises.
- Write isolation: the model drives srt_wr=1 in LOAD and DRAIN -> mem_wr never reflects it; RAM holds the loaded values.
- Reset mid-SORT: assert rst in the 5th SORT cycle -> next cycle state=LOAD, in_ready=1, busy=0, srt_start=0; a following job completes correctly.
- WATCHDOG_EN with TIMEOUT_CYC=16 and the model never asserting done -> DRAIN entered after 16 SORT cycles; sort_err=1 until the next KICK.
